// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : FSM encodings, default drain length and the per-cycle
//               control bundle for the pipeline hazard sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam int DEF_DRAIN_CYCLES = 3;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic memwb_flush;
    } pipe_ctl_t;

endpackage
`default_nettype wire

// File: rtl/pipe_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : pipe_sat_counter
// Description : W-bit up counter that sticks at all-ones; sync active-high rst.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Per-cycle hold/load/bubble control for IF/ID, ID/EX, EX/MEM,
//               MEM/WB plus the HLT drain-and-freeze sequence.
//               Define PIPE_CTRL_STATS_EN to add stall_cnt / flush_cnt outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lu_hazard,
    input  logic             br_taken,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    input  logic             hlt_id,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             halted,
    output logic [1:0]       ctrl_state
`ifdef PIPE_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    if ((DRAIN_CYCLES < 1) || (CNT_W < 1)) begin : g_param_check
        $error("pipe_hazard_ctrl: DRAIN_CYCLES and CNT_W must be at least 1");
    end

    logic [1:0]         state_q, state_d;
    logic [DRAIN_W-1:0] cnt_q, cnt_d;
    logic               halted_q;
    pipe_ctl_t          ctl;

    always_comb begin
        ctl     = '0;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (dmem_busy) begin
                    ctl.memwb_en    = 1'b1;
                    ctl.memwb_flush = 1'b1;
                end else if (lu_hazard) begin
                    ctl.idex_en    = 1'b1;
                    ctl.idex_flush = 1'b1;
                    ctl.exmem_en   = 1'b1;
                    ctl.memwb_en   = 1'b1;
                end else if (hlt_id) begin
                    // HLT moves on to ID/EX; fetch stops and IF/ID takes a bubble
                    ctl.ifid_en    = 1'b1;
                    ctl.ifid_flush = 1'b1;
                    ctl.idex_en    = 1'b1;
                    ctl.exmem_en   = 1'b1;
                    ctl.memwb_en   = 1'b1;
                    state_d        = ST_DRAIN;
                    cnt_d          = DRAIN_LOAD;
                end else begin
                    ctl.pc_en      = br_taken | ~imem_busy;
                    ctl.ifid_en    = 1'b1;
                    ctl.ifid_flush = br_taken | imem_busy;
                    ctl.idex_en    = 1'b1;
                    ctl.exmem_en   = 1'b1;
                    ctl.memwb_en   = 1'b1;
                end
            end
            ST_DRAIN: begin
                ctl.ifid_flush = 1'b1;
                if (dmem_busy) begin
                    ctl.memwb_en    = 1'b1;
                    ctl.memwb_flush = 1'b1;
                end else begin
                    ctl.ifid_en  = 1'b1;
                    ctl.idex_en  = 1'b1;
                    ctl.exmem_en = 1'b1;
                    ctl.memwb_en = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = ST_HALTED;
                    end else begin
                        cnt_d = cnt_q - DRAIN_W'(1);
                    end
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            halted_q <= (state_d == ST_HALTED);
        end
    end

    assign pc_en       = ctl.pc_en;
    assign ifid_en     = ctl.ifid_en;
    assign idex_en     = ctl.idex_en;
    assign exmem_en    = ctl.exmem_en;
    assign memwb_en    = ctl.memwb_en;
    assign ifid_flush  = ctl.ifid_flush;
    assign idex_flush  = ctl.idex_flush;
    assign exmem_flush = ctl.exmem_flush;
    assign memwb_flush = ctl.memwb_flush;
    assign halted      = halted_q;
    assign ctrl_state  = state_q;

`ifdef PIPE_CTRL_STATS_EN
    logic stall_inc;
    logic flush_inc;

    // Only RUN cycles count, so both counters freeze once HALTED
    assign stall_inc = (state_q == ST_RUN) && !ctl.pc_en;
    assign flush_inc = (state_q == ST_RUN) && br_taken && !dmem_busy
                       && !lu_hazard && !hlt_id;

    pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (stall_inc),
        .count_o (stall_cnt)
    );

    pipe_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (flush_inc),
        .count_o (flush_cnt)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Vector table plus hand-written drain/reset sequences with a
//               queue-based scoreboard for pipe_hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 16;

    // {pc, ifid, idex, exmem, memwb, ifid_f, idex_f, exmem_f, memwb_f}
    localparam logic [8:0] C_NORM  = 9'b11111_0000;
    localparam logic [8:0] C_DMEM  = 9'b00001_0001;
    localparam logic [8:0] C_LU    = 9'b00111_0100;
    localparam logic [8:0] C_BR    = 9'b11111_1000;
    localparam logic [8:0] C_IMEM  = 9'b01111_1000;
    localparam logic [8:0] C_HLT   = 9'b01111_1000;
    localparam logic [8:0] C_DRN   = 9'b01111_1000;
    localparam logic [8:0] C_DRNDM = 9'b00001_1001;
    localparam logic [8:0] C_HALT  = 9'b00000_0000;

    logic clk = 1'b0;
    logic rst, lu_hazard, br_taken, imem_busy, dmem_busy, hlt_id;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic halted;
    logic [1:0] ctrl_state;
`ifdef PIPE_CTRL_STATS_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    int stall_exp = 0;
    int flush_exp = 0;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .lu_hazard   (lu_hazard),
        .br_taken    (br_taken),
        .imem_busy   (imem_busy),
        .dmem_busy   (dmem_busy),
        .hlt_id      (hlt_id),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .idex_en     (idex_en),
        .exmem_en    (exmem_en),
        .memwb_en    (memwb_en),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .exmem_flush (exmem_flush),
        .memwb_flush (memwb_flush),
        .halted      (halted),
        .ctrl_state  (ctrl_state)
`ifdef PIPE_CTRL_STATS_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    typedef struct {
        logic       lu, br, im, dm, hl;
        logic [8:0] ctl;
        string      name;
    } vec_t;

    typedef struct {
        logic [8:0] ctl;
        logic [1:0] st;
        logic       hlt;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Drive one cycle of inputs at negedge, queue the expectation, check before posedge
    task automatic step(input logic r, input logic lu, input logic br, input logic im,
                        input logic dm, input logic hl, input logic [8:0] ectl,
                        input logic [1:0] est, input logic eh, input string nm);
        exp_t e;
        logic [8:0] act;
        @(negedge clk);
        rst = r; lu_hazard = lu; br_taken = br; imem_busy = im; dmem_busy = dm; hlt_id = hl;
        exp_q.push_back('{ectl, est, eh, nm});
        #2;
        e = exp_q.pop_front();
        act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush};
        cmp({e.name, ".ctl"},    16'(act),        16'(e.ctl));
        cmp({e.name, ".state"},  16'(ctrl_state), 16'(e.st));
        cmp({e.name, ".halted"}, 16'(halted),     16'(e.hlt));
`ifdef PIPE_CTRL_STATS_EN
        cmp({e.name, ".stall_cnt"}, 16'(stall_cnt), 16'(stall_exp));
        cmp({e.name, ".flush_cnt"}, 16'(flush_cnt), 16'(flush_exp));
        if (r) begin
            stall_exp = 0;
            flush_exp = 0;
        end else if (est == 2'd0) begin
            if (!ectl[8]) stall_exp++;
            if (br && !dm && !lu && !hl) flush_exp++;
        end
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; lu_hazard = 0; br_taken = 0; imem_busy = 0; dmem_busy = 0; hlt_id = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
`ifdef PIPE_CTRL_STATS_EN
        stall_exp = 0;
        flush_exp = 0;
`endif
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{0, 0, 0, 0, 0, C_NORM, "idle"});
        vecs.push_back('{1, 0, 0, 0, 0, C_LU,   "lu"});
        vecs.push_back('{0, 0, 0, 0, 0, C_NORM, "after_lu"});
        vecs.push_back('{0, 1, 0, 0, 0, C_BR,   "br"});
        vecs.push_back('{0, 0, 1, 0, 0, C_IMEM, "imem"});
        vecs.push_back('{0, 1, 1, 0, 0, C_BR,   "br_imem"});
        vecs.push_back('{0, 0, 0, 1, 0, C_DMEM, "dmem"});
        vecs.push_back('{1, 1, 0, 0, 0, C_LU,   "lu_br"});
        vecs.push_back('{1, 0, 1, 0, 1, C_LU,   "lu_imem_hlt"});
        vecs.push_back('{1, 1, 1, 1, 1, C_DMEM, "dmem_all"});
        vecs.push_back('{0, 0, 0, 0, 0, C_NORM, "idle2"});

        rst = 1'b1; lu_hazard = 0; br_taken = 0; imem_busy = 0; dmem_busy = 0; hlt_id = 0;
        repeat (2) @(posedge clk);
        step(0, 0, 0, 0, 0, 0, C_NORM, 2'd0, 1'b0, "reset_state");

        foreach (vecs[i]) begin
            step(0, vecs[i].lu, vecs[i].br, vecs[i].im, vecs[i].dm, vecs[i].hl,
                 vecs[i].ctl, 2'd0, 1'b0, vecs[i].name);
        end

        for (int k = 0; k < 4; k++) begin
            step(0, 1, 0, 0, 1, 0, C_DMEM, 2'd0, 1'b0, "dmem4_lu");
        end
        step(0, 0, 0, 0, 0, 0, C_NORM, 2'd0, 1'b0, "dmem4_release");

        // Plain drain: HLT at T, halted at T+4; hazards ignored while draining
        step(0, 0, 0, 0, 0, 1, C_HLT,  2'd0, 1'b0, "hlt_T");
        step(0, 1, 1, 0, 0, 1, C_DRN,  2'd1, 1'b0, "drain_T1");
        step(0, 0, 0, 1, 0, 0, C_DRN,  2'd1, 1'b0, "drain_T2");
        step(0, 0, 0, 0, 0, 0, C_DRN,  2'd1, 1'b0, "drain_T3");
        step(0, 0, 1, 0, 0, 0, C_HALT, 2'd2, 1'b1, "halted_T4");
        step(0, 1, 1, 1, 1, 1, C_HALT, 2'd2, 1'b1, "halted_T5");
        step(1, 0, 0, 0, 0, 0, C_HALT, 2'd2, 1'b1, "halted_rst");
        step(0, 0, 0, 0, 0, 0, C_NORM, 2'd0, 1'b0, "after_halt_rst");

        // Drain stretched by dmem_busy at T+2
        step(0, 0, 0, 0, 0, 1, C_HLT,   2'd0, 1'b0, "hlt2_T");
        step(0, 0, 0, 0, 0, 0, C_DRN,   2'd1, 1'b0, "drain2_T1");
        step(0, 0, 0, 0, 1, 0, C_DRNDM, 2'd1, 1'b0, "drain2_T2_dmem");
        step(0, 0, 0, 0, 0, 0, C_DRN,   2'd1, 1'b0, "drain2_T3");
        step(0, 0, 0, 0, 0, 0, C_DRN,   2'd1, 1'b0, "drain2_T4");
        step(0, 0, 0, 0, 0, 0, C_HALT,  2'd2, 1'b1, "halted2_T5");

        // Reset in the middle of a drain
        do_reset();
        step(0, 0, 0, 0, 0, 1, C_HLT,  2'd0, 1'b0, "hlt3_T");
        step(0, 0, 0, 0, 0, 0, C_DRN,  2'd1, 1'b0, "drain3_T1");
        step(1, 0, 0, 0, 0, 0, C_DRN,  2'd1, 1'b0, "drain3_T2_rst");
        step(0, 0, 0, 0, 0, 0, C_NORM, 2'd0, 1'b0, "drain3_T3_run");
        step(0, 0, 1, 1, 0, 0, C_BR,   2'd0, 1'b0, "drain3_br_imem");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
